joy_db15_tx: RTL and testbench



---
 rtl/joy_db15_tx.sv | 109 ++++++++++
 tb/tb_joy_db15_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick shift chain: snapshots two players' buttons on JOY_LOAD
// and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge.
module joy_db15_tx #(
  parameter int PW         = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit FILL       = 1'b1,
  localparam int FB        = 2 * PW,
  localparam int CW        = $clog2(FB) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] joystick1,
  input  logic [PW-1:0] joystick2,
  input  logic          JOY_LOAD,
  input  logic          JOY_CLK,
  output logic          JOY_DATA,
  output logic          frame_done,
  output logic [CW-1:0] bit_cnt,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] FB_CNT = CW'(FB);

  state_t        state;
  logic [FB-1:0] sr;
  logic [FB-1:0] w;
  logic [CW-1:0] cnt_nxt;
  logic          load_s1, load_s2, load_s3;
  logic          jclk_s1, jclk_s2, jclk_s3;
  logic          load_low, load_rise, jclk_rise;

  assign w         = ACTIVE_LOW ? ~{joystick2, joystick1} : {joystick2, joystick1};
  assign load_low  = ~load_s2;
  assign load_rise = load_s2 & ~load_s3;
  assign jclk_rise = jclk_s2 & ~jclk_s3;
  assign cnt_nxt   = bit_cnt + 1'b1;
  assign state_dbg = state;

  // sr[0] is always the bit on the wire: sr holds W while loading, and it is all FILL
  // after reset and after the last shift, so IDLE/DONE drive FILL with no extra mux.
  assign JOY_DATA  = sr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      load_s1 <= 1'b1;
      load_s2 <= 1'b1;
      load_s3 <= 1'b1;
      jclk_s1 <= 1'b1;
      jclk_s2 <= 1'b1;
      jclk_s3 <= 1'b1;
    end else begin
      load_s1 <= JOY_LOAD;
      load_s2 <= load_s1;
      load_s3 <= load_s2;
      jclk_s1 <= JOY_CLK;
      jclk_s2 <= jclk_s1;
      jclk_s3 <= jclk_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= {FB{FILL}};
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_low) begin
            state   <= LOAD;
            sr      <= w;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          // Transparent while load is held; a clock edge seen with the load edge is dropped.
          sr      <= w;
          bit_cnt <= '0;
          if (load_rise) state <= SHIFT;
        end
        SHIFT: begin
          if (load_low) begin
            state   <= LOAD;
            sr      <= w;
            bit_cnt <= '0;
          end else if (jclk_rise) begin
            sr      <= {FILL, sr[FB-1:1]};
            bit_cnt <= cnt_nxt;
            if (cnt_nxt == FB_CNT) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: scoreboard of expected serial bits per frame,
// checked after every JOY_CLK edge, plus abort, same-cycle, reset and saturation cases.
module tb_joy_db15_tx;

  localparam int PW = 16;
  localparam int FB = 2 * PW;
  localparam int CW = $clog2(FB) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] joystick1;
  logic [PW-1:0] joystick2;
  logic          JOY_LOAD;
  logic          JOY_CLK;
  logic          JOY_DATA;
  logic          frame_done;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int exp_cnt = 0;
  int fd0;
  logic [0:0] exp_q[$];

  joy_db15_tx #(.PW(PW), .ACTIVE_LOW(1'b1), .FILL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_CLK    (JOY_CLK),
    .JOY_DATA   (JOY_DATA),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Every clk cycle with frame_done high counts, so a wide pulse shows up as extra counts.
  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [PW-1:0] j1, input logic [PW-1:0] j2);
    logic [FB-1:0] wire_word;
    wire_word = ~{j2, j1};
    exp_q.delete();
    for (int i = 0; i < FB; i++) exp_q.push_back(wire_word[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic do_load(input logic [PW-1:0] j1, input logic [PW-1:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    push_frame(j1, j2);
    JOY_LOAD = 1'b0;
    wait_cyc(6);
    JOY_LOAD = 1'b1;
    wait_cyc(6);
    chk("load_data", {31'd0, JOY_DATA}, {31'd0, exp_q.pop_front()});
    chk("load_cnt", {26'd0, bit_cnt}, 32'd0);
    exp_cnt = 0;
  endtask

  task automatic edge_chk();
    JOY_CLK = 1'b1;
    wait_cyc(6);
    exp_cnt = (exp_cnt < FB) ? exp_cnt + 1 : FB;
    if (exp_q.size() > 0)
      chk($sformatf("bit_after_edge%0d", exp_cnt), {31'd0, JOY_DATA}, {31'd0, exp_q.pop_front()});
    else
      chk("fill_after_frame", {31'd0, JOY_DATA}, 32'd1);
    chk($sformatf("cnt_edge%0d", exp_cnt), {26'd0, bit_cnt}, exp_cnt);
    JOY_CLK = 1'b0;
    wait_cyc(6);
  endtask

  initial begin
    reset     = 1'b1;
    JOY_LOAD  = 1'b1;
    JOY_CLK   = 1'b0;
    joystick1 = '0;
    joystick2 = '0;
    wait_cyc(3);
    chk("rst_data", {31'd0, JOY_DATA}, 32'd1);
    chk("rst_cnt", {26'd0, bit_cnt}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    wait_cyc(2);

    // JOY_CLK with load high: idle line stays at FILL
    for (int i = 0; i < 4; i++) begin
      JOY_CLK = 1'b1;
      wait_cyc(6);
      chk("idle_data", {31'd0, JOY_DATA}, 32'd1);
      chk("idle_cnt", {26'd0, bit_cnt}, 32'd0);
      JOY_CLK = 1'b0;
      wait_cyc(6);
    end

    // Basic frame
    fd0 = fd_cnt;
    do_load(16'h0011, 16'h8000);
    repeat (FB) edge_chk();
    chk("frame1_fd", fd_cnt, fd0 + 1);
    chk("frame1_state", {30'd0, state_dbg}, 32'd3);
    chk("frame1_fill", {31'd0, JOY_DATA}, 32'd1);

    // Inputs changing after the load edge must not alter the stream
    fd0 = fd_cnt;
    do_load(16'h0011, 16'h8000);
    joystick1 = 16'hFFFF;
    repeat (FB) edge_chk();
    chk("frozen_fd", fd_cnt, fd0 + 1);

    // Abort mid-frame with a new load
    do_load(16'h0011, 16'h8000);
    repeat (10) edge_chk();
    fd0 = fd_cnt;
    do_load(16'h0001, 16'h0000);
    chk("abort_no_fd", fd_cnt, fd0);
    repeat (FB) edge_chk();
    chk("abort_new_fd", fd_cnt, fd0 + 1);

    // JOY_CLK rise on the same cycle as the load rise is ignored
    fd0 = fd_cnt;
    joystick1 = 16'h0002;
    joystick2 = 16'h1234;
    push_frame(16'h0002, 16'h1234);
    JOY_LOAD = 1'b0;
    wait_cyc(6);
    JOY_LOAD = 1'b1;
    JOY_CLK  = 1'b1;
    wait_cyc(6);
    chk("same_cyc_data", {31'd0, JOY_DATA}, {31'd0, exp_q.pop_front()});
    chk("same_cyc_cnt", {26'd0, bit_cnt}, 32'd0);
    exp_cnt = 0;
    JOY_CLK = 1'b0;
    wait_cyc(6);
    repeat (FB) edge_chk();
    chk("same_cyc_fd", fd_cnt, fd0 + 1);

    // Reset in the middle of a frame (bit 20 on the wire is 0)
    do_load(16'h00A5, 16'h0010);
    repeat (20) edge_chk();
    fd0 = fd_cnt;
    reset = 1'b1;
    wait_cyc(1);
    chk("midrst_data", {31'd0, JOY_DATA}, 32'd1);
    chk("midrst_cnt", {26'd0, bit_cnt}, 32'd0);
    chk("midrst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    wait_cyc(2);
    chk("midrst_state", {30'd0, state_dbg}, 32'd0);
    chk("midrst_no_fd", fd_cnt, fd0);
    exp_q.delete();

    // Full frame then extra edges: count saturates, line stays FILL
    fd0 = fd_cnt;
    do_load(16'h0011, 16'h8000);
    repeat (FB) edge_chk();
    repeat (36) edge_chk();
    chk("sat_cnt", {26'd0, bit_cnt}, FB);
    chk("sat_data", {31'd0, JOY_DATA}, 32'd1);
    chk("sat_fd", fd_cnt, fd0 + 1);
    chk("sat_state", {30'd0, state_dbg}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
